led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq.sv | 131 +++++++++++++
 tb/tb_led_pattern_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a debounced mode button cycles BLINK/COUNT/SCAN/FILL,
// and the upstream tick strobe steps the current pattern unless paused.
module led_pattern_seq #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       pause,
    output logic [7:0] LEDG,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        BLINK = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        FILL  = 2'd3
    } mode_t;

    localparam int              CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             btn_meta;
    logic             btn_sync;
    logic             pause_meta;
    logic             pause_sync;
    logic [CNT_W-1:0] deb_cnt;
    logic             btn_deb;
    logic             btn_deb_d;
    logic             press;

    mode_t            mode_q;
    mode_t            mode_n;
    logic [7:0]       led_q;
    logic [7:0]       led_n;
    logic             dir_q;
    logic             dir_n;

    // Synchronizers reset to the idle levels so reset release never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_meta   <= 1'b1;
            btn_sync   <= 1'b1;
            pause_meta <= 1'b0;
            pause_sync <= 1'b0;
        end else begin
            btn_meta   <= mode_btn;
            btn_sync   <= btn_meta;
            pause_meta <= pause;
            pause_sync <= pause_meta;
        end
    end

    // A mismatch against the accepted level counts up; any return to it clears the count.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_cnt   <= '0;
            btn_deb   <= 1'b1;
            btn_deb_d <= 1'b1;
        end else begin
            btn_deb_d <= btn_deb;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                btn_deb <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = btn_deb_d & ~btn_deb;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q <= BLINK;
        end else begin
            mode_q <= mode_n;
        end
    end

    always_comb begin
        mode_n = mode_q;
        if (press) begin
            mode_n = mode_t'(mode_q + 2'd1);
        end
    end

    // A press reloads the start value and swallows any coincident tick.
    always_comb begin
        led_n = led_q;
        dir_n = dir_q;
        if (press) begin
            dir_n = 1'b0;
            led_n = (mode_n == SCAN) ? 8'h01 : 8'h00;
        end else if (tick && !pause_sync) begin
            case (mode_q)
                BLINK: led_n = ~led_q;
                COUNT: led_n = led_q + 8'd1;
                SCAN: begin
                    if (!dir_q) begin
                        led_n = {led_q[6:0], 1'b0};
                        if (led_q == 8'h40) dir_n = 1'b1;
                    end else begin
                        led_n = {1'b0, led_q[7:1]};
                        if (led_q == 8'h02) dir_n = 1'b0;
                    end
                end
                FILL: led_n = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
                default: led_n = led_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q <= 8'h00;
            dir_q <= 1'b0;
        end else begin
            led_q <= led_n;
            dir_q <= dir_n;
        end
    end

    assign LEDG = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with a short debounce window.
module tb_led_pattern_seq;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       mode_btn;
    logic       pause;
    logic [7:0] ledg;
    logic [1:0] mode;

    int tests;
    int failures;

    led_pattern_seq #(.DEB_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .tick     (tick),
        .mode_btn (mode_btn),
        .pause    (pause),
        .LEDG     (ledg),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic press_button();
        mode_btn = 1'b0;
        repeat (10) @(negedge clk);
        mode_btn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'hFF, 8'h00, 8'hFF};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (mode !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_mode: got %0d expected 0", mode);
        end
        tests++;
        if (ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_ledg: got %h expected 00", ledg);
        end
        for (int i = 0; i < 3; i++) begin
            step_tick();
            tests++;
            if (ledg !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL blink_tick%0d: got %h expected %h", i, ledg, exp_seq[i]);
            end
        end
        // Partial debounce interrupted by reset must not produce a press.
        mode_btn = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mode_btn = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (mode !== 2'd0 || ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_mid_debounce: got mode %0d ledg %h expected 0 00", mode, ledg);
        end
        step_tick();
    endtask

    task automatic test_debounce();
        logic [1:0] exp_modes [4];
        exp_modes = '{2'd2, 2'd3, 2'd0, 2'd1};
        mode_btn = 1'b0;
        repeat (3) @(negedge clk);
        mode_btn = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (mode !== 2'd0 || ledg !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL glitch: got mode %0d ledg %h expected 0 ff", mode, ledg);
        end
        mode_btn = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (mode !== 2'd0) begin
            failures++;
            $display("[TB] FAIL press_early: got %0d expected 0", mode);
        end
        @(negedge clk);
        tests++;
        if (mode !== 2'd1 || ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL press_latency: got mode %0d ledg %h expected 1 00", mode, ledg);
        end
        repeat (3) @(negedge clk);
        mode_btn = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (mode !== 2'd1) begin
            failures++;
            $display("[TB] FAIL hold_release: got %0d expected 1", mode);
        end
        for (int i = 0; i < 4; i++) begin
            press_button();
            tests++;
            if (mode !== exp_modes[i]) begin
                failures++;
                $display("[TB] FAIL press_seq%0d: got %0d expected %0d", i, mode, exp_modes[i]);
            end
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 1; i <= 256; i++) begin
            step_tick();
            if (i == 1 || i == 255 || i == 256) begin
                tests++;
                if (ledg !== 8'(i)) begin
                    failures++;
                    $display("[TB] FAIL count_tick%0d: got %h expected %h", i, ledg, 8'(i));
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_seq [16];
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        press_button();
        tests++;
        if (mode !== 2'd2 || ledg !== 8'h01) begin
            failures++;
            $display("[TB] FAIL scan_entry: got mode %0d ledg %h expected 2 01", mode, ledg);
        end
        for (int i = 0; i < 16; i++) begin
            step_tick();
            tests++;
            if (ledg !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL scan_tick%0d: got %h expected %h", i, ledg, exp_seq[i]);
            end
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        press_button();
        tests++;
        if (mode !== 2'd3 || ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL fill_entry: got mode %0d ledg %h expected 3 00", mode, ledg);
        end
        for (int i = 0; i < 9; i++) begin
            step_tick();
            tests++;
            if (ledg !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL fill_tick%0d: got %h expected %h", i, ledg, exp_seq[i]);
            end
        end
        press_button();
        tests++;
        if (mode !== 2'd0 || ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL fill_wrap_mode: got mode %0d ledg %h expected 0 00", mode, ledg);
        end
    endtask

    task automatic test_collision();
        step_tick();
        mode_btn = 1'b0;
        repeat (6) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        tests++;
        if (mode !== 2'd1 || ledg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL press_tick_collision: got mode %0d ledg %h expected 1 00", mode, ledg);
        end
        repeat (3) @(negedge clk);
        mode_btn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_pause();
        step_tick();
        step_tick();
        pause = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) step_tick();
        tests++;
        if (ledg !== 8'h02) begin
            failures++;
            $display("[TB] FAIL pause_hold: got %h expected 02", ledg);
        end
        press_button();
        tests++;
        if (mode !== 2'd2 || ledg !== 8'h01) begin
            failures++;
            $display("[TB] FAIL pause_press: got mode %0d ledg %h expected 2 01", mode, ledg);
        end
        step_tick();
        tests++;
        if (ledg !== 8'h01) begin
            failures++;
            $display("[TB] FAIL pause_scan_hold: got %h expected 01", ledg);
        end
        pause = 1'b0;
        repeat (3) @(negedge clk);
        step_tick();
        tests++;
        if (ledg !== 8'h02) begin
            failures++;
            $display("[TB] FAIL unpause_step: got %h expected 02", ledg);
        end
    endtask

    task automatic test_async_reset();
        step_tick();
        step_tick();
        step_tick();
        tests++;
        if (ledg !== 8'h10 || mode !== 2'd2) begin
            failures++;
            $display("[TB] FAIL pre_reset_scan: got mode %0d ledg %h expected 2 10", mode, ledg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ledg !== 8'h00 || mode !== 2'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got mode %0d ledg %h expected 0 00", mode, ledg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step_tick();
        tests++;
        if (ledg !== 8'hFF || mode !== 2'd0) begin
            failures++;
            $display("[TB] FAIL post_reset_blink: got mode %0d ledg %h expected 0 ff", mode, ledg);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        tick     = 1'b0;
        mode_btn = 1'b1;
        pause    = 1'b0;
        test_reset();
        test_debounce();
        test_count_wrap();
        test_scan();
        test_fill();
        test_collision();
        test_pause();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
